decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have parameter OP_W, default 4, width of the ALU op code.
REQ-003 SHALL have ports:
 clk  in  1  sole clock; all state on rising edge.
 rst_n  in  1  reset, asynchronous, active-low.
 if_valid  in  1  fetch offers an instruction.
 if_ready  out  1  stage accepts this cycle.
 if_instr  in  32  RV32 instruction word.
 if_pc  in  32  its PC.
 rs1_addr, rs2_addr  out  5 each  register-file read addresses, combinational from if_instr.
 rs1_data, rs2_data  in  32 each  register-file read data, same cycle.
 wb_we  in  1  writeback write enable.
 wb_rd  in  5  writeback destination.
 wb_data  in  32  writeback value.
 flush  in  1  kill held and incoming instruction (taken branch).
 ex_valid  out  1  execute-stage payload valid.
 ex_ready  in  1  execute stage consumes.
 ex_data1, ex_data2  out  32 each  ALU operands.
 ex_op  out  4  ALU op code.
 ex_rd  out  5  destination register.
 ex_we  out  1  result is written back.
 ex_branch  out  1  instruction is a conditional branch.
 ex_pc  out  32  PC of held instruction.
 ex_imm  out  32  sign-extended B-immediate (branches), else 0.
 ex_illegal  out  1  unsupported encoding.

Function
REQ-004 SHALL implement one pipeline register; if_ready = !ex_valid | ex_ready, forced 0 while flush=1.
REQ-005 SHALL capture decode results when if_valid & if_ready; ex_valid=1 next cycle; latency exactly 1 cycle.
REQ-006 SHALL clear ex_valid when ex_valid & ex_ready and no capture; back-to-back capture when both occur.
REQ-007 SHALL hold all ex_* outputs stable while ex_valid & !ex_ready.
REQ-008 SHALL, on flush=1, clear ex_valid next cycle and drop any simultaneous offer; flush wins over capture and ex_ready.
REQ-009 SHALL bypass: at capture, operand for rsN = wb_data if wb_we & wb_rd==rsN & rsN!=0, else rs data; register 0 always reads 0.
REQ-010 SHALL map op codes: ADD/ADDI 0, SUB 1, AND/ANDI 2, OR/ORI 3, XOR/XORI 4, SLL/SLLI 6, SRL/SRLI 7, SLTU/SLTIU 11.
REQ-011 SHALL form data2 for I-type as sign-extended imm[11:0]; for SLLI/SRLI as zero-extended shamt[4:0].
REQ-012 SHALL decode LUI as op 0, data1=0, data2={imm[31:12],12'b0}; AUIPC as op 0, data1=if_pc, same data2.
REQ-013 SHALL decode BEQ op 8, BNE op 9, BGEU op 10, BLTU op 11 with ex_branch=1, ex_we=0, data1/data2=rs1/rs2, ex_imm=B-imm.
REQ-014 SHALL set ex_we=1 and ex_rd=instr[11:7] for ALU, LUI, AUIPC; ex_rd=0 otherwise.
REQ-015 SHALL flag all other encodings (loads, stores, JAL/JALR, SRA, SLT, BLT, BGE, bad funct7) ex_illegal=1, ex_op=15, ex_we=0, ex_branch=0, data 0.

Reset
REQ-016 SHALL, while rst_n=0, drive ex_valid=0 and all registered ex_* outputs to 0, regardless of clk.
REQ-017 SHALL drop an in-flight instruction on reset mid-operation; first capture possible on first edge after deassertion.

Structure
REQ-018 SHALL place ALU op code constants (0..11, 15 illegal) and RV32 opcode/funct constants in a shared package also used by the ALU.
REQ-019 SHALL use one combinational sub-module, instr_decoder (instr, pc -> op, imm, control flags); pipeline register and bypass stay in decode_stage.

Verification
REQ-020 SHALL check: ADDI x1,x0,5 offered, ex_ready=1 -> next cycle ex_valid=1, op 0, data1=0, data2=5, ex_rd=1, ex_we=1.
REQ-021 SHALL check: SUB x3,x1,x2 with wb_we=1, wb_rd=2, wb_data=7, rs2_data=9 -> data2=7, op 1.
REQ-022 SHALL check: ex_ready=0 for 3 cycles with if_valid=1 -> if_ready=0, ex_* unchanged; ex_ready=1 -> next instruction captured same edge.
REQ-023 SHALL check: BNE x1,x2,-8 -> op 9, ex_branch=1, ex_we=0, ex_imm=0xFFFFFFF8.
REQ-024 SHALL check: flush=1 with if_valid=1 and ex_valid=1 -> ex_valid=0 next cycle, offered instruction not captured.
REQ-025 SHALL check: LW 0x00002083 -> ex_illegal=1, ex_op=15, ex_we=0; rst_n low mid-stall -> ex_valid=0 immediately.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: ALU op codes, RV32 opcode/funct constants and decode payload types
package decode_stage_pkg;

  localparam logic [3:0] ALU_ADD     = 4'd0;
  localparam logic [3:0] ALU_SUB     = 4'd1;
  localparam logic [3:0] ALU_AND     = 4'd2;
  localparam logic [3:0] ALU_OR      = 4'd3;
  localparam logic [3:0] ALU_XOR     = 4'd4;
  localparam logic [3:0] ALU_SLL     = 4'd6;
  localparam logic [3:0] ALU_SRL     = 4'd7;
  localparam logic [3:0] ALU_BEQ     = 4'd8;
  localparam logic [3:0] ALU_BNE     = 4'd9;
  localparam logic [3:0] ALU_BGEU    = 4'd10;
  localparam logic [3:0] ALU_SLTU    = 4'd11;
  localparam logic [3:0] ALU_BLTU    = 4'd11;
  localparam logic [3:0] ALU_ILLEGAL = 4'd15;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        use_rs1;
    logic        use_rs2;
    logic [31:0] base1;
    logic [31:0] imm;
    logic [31:0] bimm;
    logic        we;
    logic        branch;
    logic        illegal;
  } dec_t;

  typedef struct packed {
    logic [31:0] data1;
    logic [31:0] data2;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        we;
    logic        branch;
    logic        illegal;
  } ex_pkt_t;

  function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic sub);
    case (f3)
      F3_ADD:  arith_op = sub ? ALU_SUB : ALU_ADD;
      F3_SLL:  arith_op = ALU_SLL;
      F3_SLTU: arith_op = ALU_SLTU;
      F3_XOR:  arith_op = ALU_XOR;
      F3_SRL:  arith_op = ALU_SRL;
      F3_OR:   arith_op = ALU_OR;
      F3_AND:  arith_op = ALU_AND;
      default: arith_op = ALU_ILLEGAL;
    endcase
  endfunction

  function automatic logic [3:0] branch_op(input logic [2:0] f3);
    case (f3)
      F3_BEQ:  branch_op = ALU_BEQ;
      F3_BNE:  branch_op = ALU_BNE;
      F3_BLTU: branch_op = ALU_BLTU;
      F3_BGEU: branch_op = ALU_BGEU;
      default: branch_op = ALU_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_decoder.sv
// instr_decoder: combinational RV32 subset decode into op code, immediates and control flags
module instr_decoder
  import decode_stage_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output dec_t        dec
);

  logic [6:0] opc;
  logic [6:0] f7;
  logic [2:0] f3;
  dec_t       raw;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];
  assign rs1 = instr[19:15];
  assign rs2 = instr[24:20];

  // per-opcode decode; anything unrecognised keeps the illegal op code
  always_comb begin
    raw    = '0;
    raw.op = ALU_ILLEGAL;
    case (opc)
      OPC_OP: begin
        raw.op      = (f7 == F7_BASE || (f7 == F7_ALT && f3 == F3_ADD)) ? arith_op(f3, f7[5]) : ALU_ILLEGAL;
        raw.use_rs1 = 1'b1;
        raw.use_rs2 = 1'b1;
        raw.we      = 1'b1;
      end
      OPC_IMM: begin
        raw.op      = (f3[1:0] != 2'b01 || f7 == F7_BASE) ? arith_op(f3, 1'b0) : ALU_ILLEGAL;
        raw.use_rs1 = 1'b1;
        raw.imm     = f3[1:0] == 2'b01 ? {27'b0, instr[24:20]} : {{20{instr[31]}}, instr[31:20]};
        raw.we      = 1'b1;
      end
      OPC_LUI: begin
        raw.op  = ALU_ADD;
        raw.imm = {instr[31:12], 12'b0};
        raw.we  = 1'b1;
      end
      OPC_AUIPC: begin
        raw.op    = ALU_ADD;
        raw.base1 = pc;
        raw.imm   = {instr[31:12], 12'b0};
        raw.we    = 1'b1;
      end
      OPC_BRANCH: begin
        raw.op      = branch_op(f3);
        raw.use_rs1 = 1'b1;
        raw.use_rs2 = 1'b1;
        raw.branch  = 1'b1;
        raw.bimm    = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      default: ;
    endcase
    raw.rd = raw.we ? instr[11:7] : 5'd0;
  end

  // an illegal encoding collapses to an all-zero payload apart from op and the flag
  always_comb begin
    dec = raw;
    if (raw.op == ALU_ILLEGAL) begin
      dec         = '0;
      dec.op      = ALU_ILLEGAL;
      dec.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32 decode with writeback bypass and a single ready/valid pipeline register
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OP_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [31:0]     if_pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_data1,
  output logic [XLEN-1:0] ex_data2,
  output logic [OP_W-1:0] ex_op,
  output logic [4:0]      ex_rd,
  output logic            ex_we,
  output logic            ex_branch,
  output logic [31:0]     ex_pc,
  output logic [31:0]     ex_imm,
  output logic            ex_illegal
);

  dec_t            dec;
  ex_pkt_t         pkt_new;
  ex_pkt_t         payload_d;
  ex_pkt_t         payload_q;
  logic            ex_valid_d;
  logic            ex_valid_q;
  logic            capture;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;

  instr_decoder u_dec (
    .instr (if_instr),
    .pc    (if_pc),
    .rs1   (rs1_addr),
    .rs2   (rs2_addr),
    .dec   (dec)
  );

  assign if_ready = !flush && (!ex_valid_q || ex_ready);
  assign capture  = if_valid && if_ready;

  // register-file read with writeback bypass; x0 always reads zero and never forwards
  always_comb begin
    op1 = rs1_addr == 5'd0 ? '0 : (wb_we && wb_rd == rs1_addr) ? wb_data : rs1_data;
    op2 = rs2_addr == 5'd0 ? '0 : (wb_we && wb_rd == rs2_addr) ? wb_data : rs2_data;
  end

  // next state: flush beats capture, capture beats drain, otherwise hold
  always_comb begin
    pkt_new = '{
      data1:   dec.use_rs1 ? op1 : dec.base1,
      data2:   dec.use_rs2 ? op2 : dec.imm,
      pc:      if_pc,
      imm:     dec.bimm,
      op:      dec.op,
      rd:      dec.rd,
      we:      dec.we,
      branch:  dec.branch,
      illegal: dec.illegal
    };
    ex_valid_d = flush ? 1'b0 : capture ? 1'b1 : ex_ready ? 1'b0 : ex_valid_q;
    payload_d  = capture ? pkt_new : payload_q;
  end

  // pipeline register, cleared asynchronously so reset drops any in-flight instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      payload_q  <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      payload_q  <= payload_d;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_data1   = payload_q.data1;
  assign ex_data2   = payload_q.data2;
  assign ex_op      = payload_q.op;
  assign ex_rd      = payload_q.rd;
  assign ex_we      = payload_q.we;
  assign ex_branch  = payload_q.branch;
  assign ex_pc      = payload_q.pc;
  assign ex_imm     = payload_q.imm;
  assign ex_illegal = payload_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and randomized checks of decode_stage against an ISA-table reference model
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid, if_ready;
  logic [31:0] if_instr, if_pc;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_data1, ex_data2;
  logic [3:0]  ex_op;
  logic [4:0]  ex_rd;
  logic        ex_we, ex_branch, ex_illegal;
  logic [31:0] ex_pc, ex_imm;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_data1(ex_data1), .ex_data2(ex_data2),
    .ex_op(ex_op), .ex_rd(ex_rd), .ex_we(ex_we), .ex_branch(ex_branch),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_illegal(ex_illegal)
  );

  localparam logic [2:0] K_R = 3'd0, K_I = 3'd1, K_SH = 3'd2, K_U = 3'd3, K_UP = 3'd4, K_B = 3'd5;

  typedef struct packed {
    logic [31:0] mask;
    logic [31:0] match;
    logic [3:0]  op;
    logic [2:0]  kind;
  } row_t;

  typedef struct packed {
    logic [31:0] d1, d2, pc, imm;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        we, br, ill;
  } exp_t;

  row_t        tbl [21];
  logic [31:0] ill_tbl [10];
  exp_t        m_pkt;
  logic        m_valid;
  int          errs = 0;
  int          checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_reg(input logic [4:0] a, input logic [31:0] rf);
    if (a == 5'd0) return 32'd0;
    if (wb_we && wb_rd == a) return wb_data;
    return rf;
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    int   imm;
    e     = '0;
    e.op  = 4'd15;
    e.ill = 1'b1;
    e.pc  = pc;
    for (int i = 0; i < 21; i++) begin
      if ((ins & tbl[i].mask) == tbl[i].match) begin
        e.ill = 1'b0;
        e.op  = tbl[i].op;
        case (tbl[i].kind)
          K_R: begin
            e.d1 = rd_reg(ins[19:15], rs1_data);
            e.d2 = rd_reg(ins[24:20], rs2_data);
            e.we = 1'b1;
          end
          K_I: begin
            imm = int'(ins >> 20);
            if (imm >= 2048) imm -= 4096;
            e.d1 = rd_reg(ins[19:15], rs1_data);
            e.d2 = 32'(imm);
            e.we = 1'b1;
          end
          K_SH: begin
            e.d1 = rd_reg(ins[19:15], rs1_data);
            e.d2 = (ins >> 20) % 32;
            e.we = 1'b1;
          end
          K_U: begin
            e.d2 = ins & 32'hFFFFF000;
            e.we = 1'b1;
          end
          K_UP: begin
            e.d1 = pc;
            e.d2 = ins & 32'hFFFFF000;
            e.we = 1'b1;
          end
          default: begin
            e.d1 = rd_reg(ins[19:15], rs1_data);
            e.d2 = rd_reg(ins[24:20], rs2_data);
            e.br = 1'b1;
            imm  = int'(((ins >> 31) & 1) * 4096 + ((ins >> 7) & 1) * 2048 +
                        ((ins >> 25) & 63) * 32 + ((ins >> 8) & 15) * 2);
            if (imm >= 4096) imm -= 8192;
            e.imm = 32'(imm);
          end
        endcase
        if (e.we) e.rd = ins[11:7];
      end
    end
    return e;
  endfunction

  task automatic compare_out(input bit all);
    check("ex_valid", ex_valid, m_valid);
    if (m_valid || all) begin
      check("ex_data1", ex_data1, m_pkt.d1);
      check("ex_data2", ex_data2, m_pkt.d2);
      check("ex_op", ex_op, m_pkt.op);
      check("ex_rd", ex_rd, m_pkt.rd);
      check("ex_we", ex_we, m_pkt.we);
      check("ex_branch", ex_branch, m_pkt.br);
      check("ex_pc", ex_pc, m_pkt.pc);
      check("ex_imm", ex_imm, m_pkt.imm);
      check("ex_illegal", ex_illegal, m_pkt.ill);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic r, input logic f);
    if_valid = v;
    if_instr = ins;
    ex_ready = r;
    flush    = f;
  endtask

  // one clock: check combinational outputs, advance the model across the edge, check registered outputs
  task automatic cycle();
    logic rdy, nv;
    exp_t np;
    #1;
    rdy = !flush && (!m_valid || ex_ready);
    check("if_ready", if_ready, rdy);
    check("rs1_addr", rs1_addr, if_instr[19:15]);
    check("rs2_addr", rs2_addr, if_instr[24:20]);
    np = m_pkt;
    nv = m_valid;
    if (flush) nv = 1'b0;
    else if (if_valid && rdy) begin
      nv = 1'b1;
      np = ref_decode(if_instr, if_pc);
    end else if (ex_ready) nv = 1'b0;
    @(posedge clk);
    m_valid = nv;
    m_pkt   = np;
    #1;
    compare_out(1'b0);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] ins;
    int          r;
    tbl = '{
      '{32'hfe00707f, 32'h00000033, 4'd0,  K_R},
      '{32'hfe00707f, 32'h40000033, 4'd1,  K_R},
      '{32'hfe00707f, 32'h00001033, 4'd6,  K_R},
      '{32'hfe00707f, 32'h00003033, 4'd11, K_R},
      '{32'hfe00707f, 32'h00004033, 4'd4,  K_R},
      '{32'hfe00707f, 32'h00005033, 4'd7,  K_R},
      '{32'hfe00707f, 32'h00006033, 4'd3,  K_R},
      '{32'hfe00707f, 32'h00007033, 4'd2,  K_R},
      '{32'h0000707f, 32'h00000013, 4'd0,  K_I},
      '{32'h0000707f, 32'h00003013, 4'd11, K_I},
      '{32'h0000707f, 32'h00004013, 4'd4,  K_I},
      '{32'h0000707f, 32'h00006013, 4'd3,  K_I},
      '{32'h0000707f, 32'h00007013, 4'd2,  K_I},
      '{32'hfe00707f, 32'h00001013, 4'd6,  K_SH},
      '{32'hfe00707f, 32'h00005013, 4'd7,  K_SH},
      '{32'h0000007f, 32'h00000037, 4'd0,  K_U},
      '{32'h0000007f, 32'h00000017, 4'd0,  K_UP},
      '{32'h0000707f, 32'h00000063, 4'd8,  K_B},
      '{32'h0000707f, 32'h00001063, 4'd9,  K_B},
      '{32'h0000707f, 32'h00006063, 4'd11, K_B},
      '{32'h0000707f, 32'h00007063, 4'd10, K_B}
    };
    ill_tbl = '{32'h00002083, 32'h0020a023, 32'h0000006f, 32'h00000067, 32'h40005033,
                32'h00002033, 32'h00004063, 32'h00005063, 32'h40005013, 32'h02000033};
    rst_n = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    if_pc = 32'd0; rs1_data = 32'd0; rs2_data = 32'd0;
    wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    m_valid = 1'b0;
    m_pkt   = '0;
    repeat (2) @(negedge clk);
    compare_out(1'b1);
    rst_n = 1'b1;

    // ADDI x1,x0,5
    drive(1'b1, 32'h00500093, 1'b1, 1'b0);
    if_pc = 32'h100; rs1_data = 32'hdeadbeef; rs2_data = 32'h12345678;
    cycle();
    check("addi_valid", ex_valid, 1);
    check("addi_op", ex_op, 0);
    check("addi_d1", ex_data1, 0);
    check("addi_d2", ex_data2, 5);
    check("addi_rd", ex_rd, 1);
    check("addi_we", ex_we, 1);

    // SUB x3,x1,x2 with x2 bypassed from writeback
    drive(1'b1, 32'h402081B3, 1'b1, 1'b0);
    if_pc = 32'h104; rs1_data = 32'd11; rs2_data = 32'd9;
    wb_we = 1'b1; wb_rd = 5'd2; wb_data = 32'd7;
    cycle();
    check("sub_op", ex_op, 1);
    check("sub_d1", ex_data1, 11);
    check("sub_d2", ex_data2, 7);

    // stall three cycles with XORI x5,x6,-1 waiting, then release
    wb_we = 1'b0;
    drive(1'b1, 32'hFFF34293, 1'b0, 1'b0);
    if_pc = 32'h108; rs1_data = 32'h00001234;
    repeat (3) begin
      cycle();
      check("stall_ready", if_ready, 0);
      check("stall_op", ex_op, 1);
      check("stall_d2", ex_data2, 7);
      check("stall_rd", ex_rd, 3);
    end
    ex_ready = 1'b1;
    cycle();
    check("xori_op", ex_op, 4);
    check("xori_d1", ex_data1, 32'h1234);
    check("xori_d2", ex_data2, 32'hFFFFFFFF);
    check("xori_rd", ex_rd, 5);

    // BNE x1,x2,-8
    drive(1'b1, 32'hFE209CE3, 1'b1, 1'b0);
    if_pc = 32'h10c; rs1_data = 32'd3; rs2_data = 32'd4;
    cycle();
    check("bne_op", ex_op, 9);
    check("bne_branch", ex_branch, 1);
    check("bne_we", ex_we, 0);
    check("bne_imm", ex_imm, 32'hFFFFFFF8);

    // flush with an offer pending and a held instruction
    drive(1'b1, 32'h00500093, 1'b0, 1'b1);
    cycle();
    check("flush_valid", ex_valid, 0);
    drive(1'b0, 32'h00500093, 1'b1, 1'b0);
    cycle();
    check("flush_dropped", ex_valid, 0);

    // LW is illegal
    drive(1'b1, 32'h00002083, 1'b1, 1'b0);
    cycle();
    check("lw_illegal", ex_illegal, 1);
    check("lw_op", ex_op, 15);
    check("lw_we", ex_we, 0);

    // reset asserted mid-stall clears immediately
    drive(1'b1, 32'h00500093, 1'b0, 1'b0);
    cycle();
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", ex_valid, 0);
    check("rst_op", ex_op, 0);
    check("rst_illegal", ex_illegal, 0);
    m_valid = 1'b0;
    m_pkt   = '0;
    @(negedge clk);
    compare_out(1'b1);
    rst_n = 1'b1;
    drive(1'b1, 32'h00500093, 1'b1, 1'b0);
    cycle();
    check("post_rst_valid", ex_valid, 1);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 60) begin
        r   = int'($urandom_range(0, 20));
        ins = ($urandom & ~tbl[r].mask) | tbl[r].match;
      end else if (r < 80) begin
        r   = int'($urandom_range(0, 9));
        ins = ill_tbl[r] | ($urandom & 32'h000F8F80);
      end else ins = $urandom;
      if_pc    = $urandom;
      rs1_data = $urandom;
      rs2_data = $urandom;
      wb_we    = 1'($urandom);
      wb_data  = $urandom;
      case ($urandom_range(0, 3))
        0:       wb_rd = ins[19:15];
        1:       wb_rd = ins[24:20];
        2:       wb_rd = 5'd0;
        default: wb_rd = 5'($urandom);
      endcase
      drive($urandom_range(0, 3) != 0, ins, $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
